fifo_stream_reader: RTL and testbench



---
 rtl/fifo_stream_pkg.sv | 11 +
 rtl/stream_buf2.sv | 58 +++++
 rtl/fifo_stream_reader.sv | 112 +++++++++++
 tb/tb_fifo_stream_reader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_pkg.sv
// Shared types for the FIFO-to-stream reader: burst framing states and buffer depth.
package fifo_stream_pkg;

    typedef enum logic [0:0] {
        BS_IDLE  = 1'b0,
        BS_BURST = 1'b1
    } burst_state_e;

    localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/stream_buf2.sv
// Two-entry in-order word buffer; head is registered. Write and pop may coincide.
// Latency: write visible at head next cycle when empty. Clear overrides write and pop.
module stream_buf2
    import fifo_stream_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic [DW-1:0] wr_data,
    input  logic          pop,
    input  logic          clr,
    output logic [1:0]    count,
    output logic [1:0]    count_next,
    output logic          vld,
    output logic [DW-1:0] head
);

    logic [DW-1:0] tail;

    always_comb begin
        count_next = count;
        if (clr) begin
            count_next = 2'd0;
        end else if (wr && !pop) begin
            count_next = count + 2'd1;
        end else if (pop && !wr) begin
            count_next = count - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            vld   <= 1'b0;
            head  <= '0;
            tail  <= '0;
        end else begin
            count <= count_next;
            vld   <= (count_next != 2'd0);
            if (!clr) begin
                if (pop) begin
                    if (count == 2'(BUF_DEPTH)) begin
                        head <= tail;
                        if (wr) tail <= wr_data;
                    end else if (wr) begin
                        head <= wr_data;
                    end
                end else if (wr) begin
                    if (count == 2'd0) head <= wr_data;
                    else               tail <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a fifo_sync read port into a valid/ready stream with burst framing (m_last_o).
// Latency: pop to m_valid_o is 1 + SYNC_RD cycles. Backpressure: pops stop once stored + inflight reaches 2.
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int DW      = 32,
    parameter int SYNC_RD = 1,
    parameter int LW      = 4
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          fifo_empty_i,
    input  logic [DW-1:0] fifo_data_i,
    output logic          fifo_rd_o,
    input  logic          flush_i,
    input  logic [LW-1:0] burst_len_i,
    output logic          m_valid_o,
    input  logic          m_ready_i,
    output logic [DW-1:0] m_data_o,
    output logic          m_last_o,
    output logic          busy_o
);

    logic          handshake;
    logic [1:0]    stored;
    logic [1:0]    stored_nxt;
    logic [2:0]    occupancy;
    logic          capture;
    logic          inflight_q;
    logic          inflight_nxt;
    logic          discard_q;
    logic          discard_nxt;
    logic          last_raw;
    burst_state_e  state_q;
    burst_state_e  state_nxt;
    logic [LW-1:0] cnt_q;
    logic [LW-1:0] cnt_nxt;
    logic [LW-1:0] len_q;
    logic [LW-1:0] len_nxt;

    assign handshake = m_valid_o & m_ready_i;

    // m_ready_i feeds the pop decision combinationally so a full buffer still pops while draining.
    assign occupancy = {1'b0, stored} + {2'b00, inflight_q} - {2'b00, handshake};
    assign fifo_rd_o = ~fifo_empty_i & ~flush_i & reset_ni & (occupancy < 3'(BUF_DEPTH));

    assign capture      = (SYNC_RD != 0) ? (inflight_q & ~discard_q) : fifo_rd_o;
    assign inflight_nxt = (SYNC_RD != 0) & fifo_rd_o;
    assign discard_nxt  = flush_i & inflight_q;

    stream_buf2 #(
        .DW (DW)
    ) u_buf (
        .clk        (clk_i),
        .rst_n      (reset_ni),
        .wr         (capture),
        .wr_data    (fifo_data_i),
        .pop        (handshake),
        .clr        (flush_i),
        .count      (stored),
        .count_next (stored_nxt),
        .vld        (m_valid_o),
        .head       (m_data_o)
    );

    always_comb begin
        last_raw = (state_q == BS_IDLE) ? (burst_len_i == '0) : (cnt_q == len_q);
        m_last_o = m_valid_o & last_raw;
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        len_nxt   = len_q;
        if (flush_i) begin
            state_nxt = BS_IDLE;
            cnt_nxt   = '0;
        end else if (handshake) begin
            if (state_q == BS_IDLE) begin
                if (burst_len_i != '0) begin
                    state_nxt = BS_BURST;
                    len_nxt   = burst_len_i;
                    cnt_nxt   = LW'(1);
                end
            end else if (m_last_o) begin
                state_nxt = BS_IDLE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt_q + LW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= BS_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            inflight_q <= 1'b0;
            discard_q  <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            len_q      <= len_nxt;
            inflight_q <= inflight_nxt;
            discard_q  <= discard_nxt;
            busy_o     <= (stored_nxt != 2'd0) | inflight_nxt | discard_nxt | (state_nxt == BS_BURST);
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: SYNC_RD=1 instance with FIFO model, plus a SYNC_RD=0 instance.
module tb_fifo_stream_reader;

    localparam int DW = 32;
    localparam int LW = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;

    logic          fifo_empty;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd;
    logic          flush = 1'b0;
    logic [LW-1:0] burst_len = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;

    logic          fifo_empty0;
    logic [DW-1:0] fifo_data0;
    logic          fifo_rd0;
    logic          flush0 = 1'b0;
    logic [LW-1:0] burst_len0 = LW'(1);
    logic          m_valid0;
    logic          m_ready0 = 1'b1;
    logic [DW-1:0] m_data0;
    logic          m_last0;
    logic          busy0;

    logic [DW-1:0] fmem  [0:255];
    logic [7:0]    fwr = '0;
    logic [7:0]    frd = '0;
    logic [DW-1:0] fmem0 [0:255];
    logic [7:0]    fwr0 = '0;
    logic [7:0]    frd0 = '0;

    beat_t exp_q[$];
    beat_t mon_e;
    int    checks = 0;
    int    errors = 0;
    int    hs_cnt = 0;

    assign fifo_empty  = (frd == fwr);
    assign fifo_empty0 = (frd0 == fwr0);
    assign fifo_data0  = fmem0[frd0];

    fifo_stream_reader #(.DW(DW), .SYNC_RD(1), .LW(LW)) u_dut (
        .clk_i        (clk),
        .reset_ni     (reset_n),
        .fifo_empty_i (fifo_empty),
        .fifo_data_i  (fifo_data),
        .fifo_rd_o    (fifo_rd),
        .flush_i      (flush),
        .burst_len_i  (burst_len),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .m_data_o     (m_data),
        .m_last_o     (m_last),
        .busy_o       (busy)
    );

    fifo_stream_reader #(.DW(DW), .SYNC_RD(0), .LW(LW)) u_dut0 (
        .clk_i        (clk),
        .reset_ni     (reset_n),
        .fifo_empty_i (fifo_empty0),
        .fifo_data_i  (fifo_data0),
        .fifo_rd_o    (fifo_rd0),
        .flush_i      (flush0),
        .burst_len_i  (burst_len0),
        .m_valid_o    (m_valid0),
        .m_ready_i    (m_ready0),
        .m_data_o     (m_data0),
        .m_last_o     (m_last0),
        .busy_o       (busy0)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Synchronous-read FIFO model: data registered on the pop edge.
    always @(posedge clk) begin
        if (fifo_rd) begin
            check("no_underflow", 64'(frd != fwr), 64'd1);
            if (frd != fwr) begin
                fifo_data <= fmem[frd];
                frd       <= frd + 8'd1;
            end
        end
        if (fifo_rd0 && (frd0 != fwr0)) frd0 <= frd0 + 8'd1;
    end

    always @(negedge clk) begin
        if (reset_n && m_valid && m_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %0h, expected no beat", m_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("beat_data", 64'(m_data), 64'(mon_e.data));
                check("beat_last", 64'(m_last), 64'(mon_e.last));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w, input logic last, input logic expect_it);
        fmem[fwr] = w;
        fwr = fwr + 8'd1;
        if (expect_it) exp_q.push_back({w, last});
    endtask

    task automatic push0(input logic [DW-1:0] w);
        fmem0[fwr0] = w;
        fwr0 = fwr0 + 8'd1;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while ((m_valid || busy || exp_q.size() != 0 || frd != fwr) && k < 200) begin
            cyc(1);
            k++;
        end
        check(name, 64'(k < 200), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   k;
        int   h0;
        logic [7:0] base;

        // Reset with a word already waiting in the FIFO
        reset_n = 1'b0;
        push(32'h55, 1'b1, 1'b1);
        cyc(3);
        check("rst_fifo_rd", 64'(fifo_rd), 64'd0);
        check("rst_valid",   64'(m_valid), 64'd0);
        check("rst_data",    64'(m_data),  64'd0);
        check("rst_last",    64'(m_last),  64'd0);
        check("rst_busy",    64'(busy),    64'd0);
        reset_n = 1'b1;
        #1;
        check("rel_pop", 64'(fifo_rd), 64'd1);
        cyc(1);
        check("rel_valid_c1", 64'(m_valid), 64'd0);
        cyc(1);
        check("rel_valid_c2", 64'(m_valid), 64'd1);
        check("rel_data_c2",  64'(m_data),  64'h55);
        check("rel_last_c2",  64'(m_last),  64'd1);
        m_ready = 1'b1;
        wait_idle("drain_reset");

        // Streaming 4-beat bursts at full rate
        burst_len = LW'(3);
        for (int i = 0; i < 8; i++) push(32'hA0 + 32'(i), 1'(i % 4 == 3), 1'b1);
        k = 0;
        while (!m_valid && k < 20) begin cyc(1); k++; end
        check("stream_start", 64'(m_valid), 64'd1);
        h0 = hs_cnt;
        cyc(8);
        check("stream_throughput", 64'(hs_cnt - h0), 64'd8);
        wait_idle("drain_stream");

        // Backpressure mid-stream
        for (int i = 0; i < 8; i++) push(32'hC0 + 32'(i), 1'(i % 4 == 3), 1'b1);
        h0 = hs_cnt;
        k = 0;
        while (hs_cnt < h0 + 3 && k < 30) begin cyc(1); k++; end
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check("stall_outstanding", 64'(int'(frd) - hs_cnt <= 2), 64'd1);
        end
        check("stall_full",     64'(int'(frd) - hs_cnt), 64'd2);
        check("stall_rd_block", 64'(fifo_rd), 64'd0);
        m_ready = 1'b1;
        wait_idle("drain_backpressure");

        // Flush the cycle after a pop: buffered D0 and in-flight D1 are dropped
        m_ready   = 1'b0;
        burst_len = '0;
        base = frd;
        push(32'hD0, 1'b1, 1'b0);
        push(32'hD1, 1'b1, 1'b0);
        k = 0;
        while (frd != base + 8'd2 && k < 20) begin cyc(1); k++; end
        check("flush_setup", 64'(frd), 64'(base + 8'd2));
        flush = 1'b1;
        push(32'hB0, 1'b0, 1'b1);
        #1;
        check("flush_rd_block", 64'(fifo_rd), 64'd0);
        cyc(1);
        flush = 1'b0;
        burst_len = LW'(2);
        check("flush_valid", 64'(m_valid), 64'd0);
        push(32'hB1, 1'b0, 1'b1);
        push(32'hB2, 1'b1, 1'b1);
        m_ready = 1'b1;
        wait_idle("drain_flush");

        // Single-beat bursts
        burst_len = '0;
        for (int i = 0; i < 4; i++) push(32'hE0 + 32'(i), 1'b1, 1'b1);
        wait_idle("drain_single");

        // Maximum burst, then a single beat to show framing returned to idle
        burst_len = LW'(15);
        for (int i = 0; i < 16; i++) push(32'h100 + 32'(i), 1'(i == 15), 1'b1);
        wait_idle("drain_max");
        check("max_busy_clear", 64'(busy), 64'd0);
        burst_len = '0;
        push(32'h1FF, 1'b1, 1'b1);
        wait_idle("drain_after_max");

        // Same-cycle read FIFO: valid one cycle after the pop, one beat per cycle
        for (int i = 0; i < 4; i++) push0(32'h70 + 32'(i));
        #1;
        check("sync0_pop", 64'(fifo_rd0), 64'd1);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            check("sync0_valid", 64'(m_valid0), 64'd1);
            check("sync0_data",  64'(m_data0),  64'(32'h70 + 32'(i)));
            check("sync0_last",  64'(m_last0),  64'(i % 2 == 1));
        end
        cyc(1);
        check("sync0_drained", 64'(m_valid0), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
